// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, d = a - b - bin, LSB first,
//   one bit per clock using a single registered borrow.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start_valid  request valid (a, b, bin sampled on acceptance)
//   start_ready  block is idle and can accept a request
//   a, b         minuend / subtrahend, WIDTH bits
//   bin          borrow-in
//   d            registered difference, WIDTH bits
//   bout         final borrow-out (unsigned a < b + bin)
//   ovf          signed overflow of a - b - bin
//   done_valid   d, bout, ovf valid
//   done_ready   consumer accepts the result
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             done_valid,
   input  logic             done_ready
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             x, y, w;
   logic             diff_bit;
   logic             nxt_brw;
   logic             last_bit;
   logic [WIDTH-1:0] res_shift;

   // Full-subtractor slice on the current LSBs.
   always_comb begin
      x         = a_q[0];
      y         = b_q[0];
      w         = brw_q;
      diff_bit  = x ^ y ^ w;
      nxt_brw   = (~x & y) | (~(x ^ y) & w);
      last_bit  = (cnt_q == CW'(WIDTH - 1));
      res_shift = {diff_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      d_d     = d_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_valid && start_ready) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_shift;
            brw_d = nxt_brw;
            if (last_bit) begin
               // Counter is held on the final bit so it never wraps.
               state_d = S_DONE;
               d_d     = res_shift;
               bout_d  = nxt_brw;
               // Borrow into the MSB vs. borrow out of it.
               ovf_d   = w ^ nxt_brw;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (done_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Ready is held low while rst is asserted, so it is gated by rst as well
   // as the registered state; it rises in the first cycle after release.
   assign start_ready = (state_q == S_IDLE) && !rst;
   assign done_valid  = (state_q == S_DONE);
   assign d           = d_q;
   assign bout        = bout_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

   typedef struct {
      logic [15:0] d;
      logic        bout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic        sv8, sr8, bin8, bout8, ovf8, dv8, dr8;
   logic [7:0]  a8, b8, d8;
   logic        sv16, sr16, bin16, bout16, ovf16, dv16, dr16;
   logic [15:0] a16, b16, d16;

   exp_t q8[$];
   exp_t q16[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .start_valid(sv8), .start_ready(sr8),
      .a(a8), .b(b8), .bin(bin8),
      .d(d8), .bout(bout8), .ovf(ovf8),
      .done_valid(dv8), .done_ready(dr8)
   );

   serial_subtractor #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .start_valid(sv16), .start_ready(sr16),
      .a(a16), .b(b16), .bin(bin16),
      .d(d16), .bout(bout16), .ovf(ovf16),
      .done_valid(dv16), .done_ready(dr16)
   );

   // Behavioural reference of a - b - bin in w bits, done with wide integers.
   function automatic exp_t model(input int w, input longint ua, input longint ub, input logic ibin);
      exp_t   e;
      longint m, half, r, sa, sb, rs, bi;
      m    = longint'(1) << w;
      half = m / 2;
      bi   = ibin ? 1 : 0;
      r    = ua - ub - bi;
      e.bout = (r < 0);
      if (r < 0) r = r + m;
      e.d  = 16'(r);
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      rs   = sa - sb - bi;
      e.ovf = (rs < -half) || (rs >= half);
      return e;
   endfunction

   // Drives one request on the 8-bit DUT and returns what it produced and
   // how many edges after acceptance done_valid appeared (-1 on timeout).
   // Entered and left at a falling edge, with dr8 held high.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] gd, output logic gb, output logic go, output int lat);
      int n;
      lat = -1; gd = '0; gb = 1'b0; go = 1'b0;
      n = 0;
      while (!sr8 && n < 50) begin @(negedge clk); n++; end
      a8 = ia; b8 = ib; bin8 = ibin; sv8 = 1'b1;
      @(negedge clk);
      sv8 = 1'b0;
      n = 0;
      while (!dv8 && n < 50) begin @(negedge clk); n++; end
      if (dv8) begin
         lat = n;
         gd  = d8; gb = bout8; go = ovf8;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (sr8 !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=0", sr8); end
      checks++;
      if (dv8 !== 1'b0) begin failures++; $display("FAIL reset_done_valid got=%b exp=0", dv8); end
      checks++;
      if ({d8, bout8, ovf8} !== 10'd0) begin failures++; $display("FAIL reset_outputs got d=%h bout=%b ovf=%b exp all 0", d8, bout8, ovf8); end
      checks++;
      if ({d16, bout16, ovf16} !== 18'd0) begin failures++; $display("FAIL reset_outputs16 got d=%h exp 0", d16); end
      rst = 1'b0;
      #1;
      checks++;
      if (sr8 !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", sr8); end
      checks++;
      if (sr16 !== 1'b1) begin failures++; $display("FAIL reset_ready_after16 got=%b exp=1", sr16); end
   endtask

   task automatic test_basic();
      logic [7:0] gd; logic gb, go; int lat;
      @(negedge clk);
      run8(8'h05, 8'h03, 1'b0, gd, gb, go, lat);
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
      checks++;
      if ({gd, gb, go} !== {8'h02, 1'b0, 1'b0}) begin failures++; $display("FAIL basic_result got d=%h bout=%b ovf=%b exp d=02 bout=0 ovf=0", gd, gb, go); end
      checks++;
      if (dv8 !== 1'b0 || sr8 !== 1'b1) begin failures++; $display("FAIL basic_release got dv=%b sr=%b exp dv=0 sr=1", dv8, sr8); end
   endtask

   task automatic test_borrow_overflow();
      logic [7:0] ta[5], tb[5], td[5];
      logic       tbin[5], tbo[5], tov[5];
      logic [7:0] gd; logic gb, go; int lat;
      ta = '{8'h03, 8'h00, 8'h80, 8'h80, 8'h7F};
      tb = '{8'h05, 8'h00, 8'h01, 8'h00, 8'hFF};
      tbin = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      td = '{8'hFE, 8'hFF, 8'h7F, 8'h7F, 8'h7F};
      tbo = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         run8(ta[i], tb[i], tbin[i], gd, gb, go, lat);
         checks++;
         if ({gd, gb, go} !== {td[i], tbo[i], tov[i]} || lat !== 8) begin
            failures++;
            $display("FAIL vector%0d got d=%h bout=%b ovf=%b lat=%0d exp d=%h bout=%b ovf=%b lat=8",
                     i, gd, gb, go, lat, td[i], tbo[i], tov[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      dr8 = 1'b0;
      a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0; sv8 = 1'b1;
      @(negedge clk);
      sv8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1; sv8 = 1'b1;
      @(negedge clk);
      sv8 = 1'b0;
      n = 0;
      while (!dv8 && n < 50) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
         sv8 = k[0];
         checks++;
         if (dv8 !== 1'b1 || sr8 !== 1'b0 || {d8, bout8, ovf8} !== {8'h25, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL backpressure_hold%0d got dv=%b sr=%b d=%h bout=%b ovf=%b exp dv=1 sr=0 d=25 bout=0 ovf=0",
                     k, dv8, sr8, d8, bout8, ovf8);
         end
         @(negedge clk);
      end
      sv8 = 1'b0;
      dr8 = 1'b1;
      @(negedge clk);
      checks++;
      if (dv8 !== 1'b0 || sr8 !== 1'b1 || d8 !== 8'h25) begin
         failures++;
         $display("FAIL backpressure_release got dv=%b sr=%b d=%h exp dv=0 sr=1 d=25", dv8, sr8, d8);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] gd; logic gb, go; int lat; logic seen;
      a8 = 8'h40; b8 = 8'h01; bin8 = 1'b0; sv8 = 1'b1;
      @(negedge clk);
      sv8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (sr8 !== 1'b1 || dv8 !== 1'b0 || {d8, bout8, ovf8} !== 10'd0) begin
         failures++;
         $display("FAIL reset_mid_state got sr=%b dv=%b d=%h bout=%b ovf=%b exp sr=1 dv=0 d=00 bout=0 ovf=0",
                  sr8, dv8, d8, bout8, ovf8);
      end
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (dv8) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done got=%b exp=0", seen); end
      run8(8'h10, 8'h01, 1'b0, gd, gb, go, lat);
      checks++;
      if ({gd, gb, go} !== {8'h0F, 1'b0, 1'b0} || lat !== 8) begin
         failures++;
         $display("FAIL reset_mid_next got d=%h bout=%b ovf=%b lat=%0d exp d=0F bout=0 ovf=0 lat=8", gd, gb, go, lat);
      end
   endtask

   task automatic test_random8(input int n_ops);
      int prev;
      q8.delete();
      fork
         begin
            for (int i = 0; i < n_ops; i++) begin
               int t;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1)); sv8 = 1'b1;
               t = 0;
               while (!sr8 && t < 100) begin @(negedge clk); t++; end
               if (!sr8) begin
                  checks++; failures++;
                  $display("FAIL rand8_accept_timeout got ready=0 exp ready=1 op=%0d", i);
               end else begin
                  q8.push_back(model(8, longint'(a8), longint'(b8), bin8));
               end
               @(negedge clk);
               sv8 = 1'b0;
            end
         end
         begin
            int got, t;
            exp_t e;
            got = 0; t = 0;
            while (got < n_ops && t < n_ops * 40) begin
               @(negedge clk);
               t++;
               dr8 = ($urandom_range(0, 3) != 0);
               if (dv8 && dr8) begin
                  got++;
                  checks++;
                  if (q8.size() == 0) begin
                     failures++;
                     $display("FAIL rand8_unexpected got d=%h exp no result", d8);
                  end else begin
                     e = q8.pop_front();
                     if ({d8, bout8, ovf8} !== {e.d[7:0], e.bout, e.ovf}) begin
                        failures++;
                        $display("FAIL rand8_result got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
                                 d8, bout8, ovf8, e.d[7:0], e.bout, e.ovf);
                     end
                  end
               end
            end
            if (got < n_ops) begin
               checks++; failures++;
               $display("FAIL rand8_done_timeout got=%0d exp=%0d", got, n_ops);
            end
            dr8 = 1'b1;
         end
      join
      // Back-to-back phase: both handshakes held high.
      prev = -1;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1)); sv8 = 1'b1;
      for (int k = 0; k < 60; k++) begin
         exp_t e;
         @(negedge clk);
         if (dv8) begin
            checks++;
            e = q8.pop_front();
            if ({d8, bout8, ovf8} !== {e.d[7:0], e.bout, e.ovf}) begin
               failures++;
               $display("FAIL b2b8_result got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
                        d8, bout8, ovf8, e.d[7:0], e.bout, e.ovf);
            end
         end
         if (sr8) begin
            if (prev >= 0) begin
               checks++;
               if (cyc - prev !== 10) begin failures++; $display("FAIL b2b8_period got=%0d exp=10", cyc - prev); end
            end
            prev = cyc;
            q8.push_back(model(8, longint'(a8), longint'(b8), bin8));
            @(posedge clk);
            #1;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
         end
      end
      sv8 = 1'b0;
      for (int k = 0; k < 30 && q8.size() > 0; k++) begin
         @(negedge clk);
         if (dv8) void'(q8.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic test_random16(input int n_ops);
      int prev;
      q16.delete();
      fork
         begin
            for (int i = 0; i < n_ops; i++) begin
               int t;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom_range(0, 1)); sv16 = 1'b1;
               t = 0;
               while (!sr16 && t < 100) begin @(negedge clk); t++; end
               if (!sr16) begin
                  checks++; failures++;
                  $display("FAIL rand16_accept_timeout got ready=0 exp ready=1 op=%0d", i);
               end else begin
                  q16.push_back(model(16, longint'(a16), longint'(b16), bin16));
               end
               @(negedge clk);
               sv16 = 1'b0;
            end
         end
         begin
            int got, t;
            exp_t e;
            got = 0; t = 0;
            while (got < n_ops && t < n_ops * 50) begin
               @(negedge clk);
               t++;
               dr16 = ($urandom_range(0, 3) != 0);
               if (dv16 && dr16) begin
                  got++;
                  checks++;
                  if (q16.size() == 0) begin
                     failures++;
                     $display("FAIL rand16_unexpected got d=%h exp no result", d16);
                  end else begin
                     e = q16.pop_front();
                     if ({d16, bout16, ovf16} !== {e.d, e.bout, e.ovf}) begin
                        failures++;
                        $display("FAIL rand16_result got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
                                 d16, bout16, ovf16, e.d, e.bout, e.ovf);
                     end
                  end
               end
            end
            if (got < n_ops) begin
               checks++; failures++;
               $display("FAIL rand16_done_timeout got=%0d exp=%0d", got, n_ops);
            end
            dr16 = 1'b1;
         end
      join
      prev = -1;
      a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom_range(0, 1)); sv16 = 1'b1;
      for (int k = 0; k < 80; k++) begin
         exp_t e;
         @(negedge clk);
         if (dv16) begin
            checks++;
            e = q16.pop_front();
            if ({d16, bout16, ovf16} !== {e.d, e.bout, e.ovf}) begin
               failures++;
               $display("FAIL b2b16_result got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
                        d16, bout16, ovf16, e.d, e.bout, e.ovf);
            end
         end
         if (sr16) begin
            if (prev >= 0) begin
               checks++;
               if (cyc - prev !== 18) begin failures++; $display("FAIL b2b16_period got=%0d exp=18", cyc - prev); end
            end
            prev = cyc;
            q16.push_back(model(16, longint'(a16), longint'(b16), bin16));
            @(posedge clk);
            #1;
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom_range(0, 1));
         end
      end
      sv16 = 1'b0;
      for (int k = 0; k < 40 && q16.size() > 0; k++) begin
         @(negedge clk);
         if (dv16) void'(q16.pop_front());
      end
      @(negedge clk);
   endtask

   initial begin
      rst  = 1'b1;
      sv8  = 1'b0; a8  = '0; b8  = '0; bin8  = 1'b0; dr8  = 1'b1;
      sv16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0; dr16 = 1'b1;
      test_reset();
      test_basic();
      test_borrow_overflow();
      test_backpressure();
      test_reset_mid();
      test_random8(500);
      test_random16(500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
